// File: rtl/pingpong_frame_buffer_if.sv
// Port bundle for pingpong_frame_buffer: frame capture input, streaming read
// output and status. The design connects through the slave modport.
interface pingpong_frame_buffer_if #(
    parameter int DATA_W = 24,
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 16
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic                     frame_valid_i;
    logic [NUM_CH*DATA_W-1:0] frame_i;
    logic                     rd_valid_o;
    logic                     rd_ready_i;
    logic [DATA_W-1:0]        rd_data_o;
    logic [CH_W-1:0]          rd_ch_o;
    logic                     rd_last_o;
    logic                     buffer_ready_o;
    logic                     overflow_o;
    logic                     clear_i;
    logic [LVL_W-1:0]         wr_level_o;

    modport master (
        output frame_valid_i, frame_i, rd_ready_i, clear_i,
        input  rd_valid_o, rd_data_o, rd_ch_o, rd_last_o,
               buffer_ready_o, overflow_o, wr_level_o
    );

    modport slave (
        input  frame_valid_i, frame_i, rd_ready_i, clear_i,
        output rd_valid_o, rd_data_o, rd_ch_o, rd_last_o,
               buffer_ready_o, overflow_o, wr_level_o
    );
endinterface

// File: rtl/pingpong_frame_buffer.sv
// Two-bank frame buffer: NUM_CH-channel frames fill one bank while the other
// bank is streamed out word by word over valid/ready.
module pingpong_frame_buffer #(
    parameter int DATA_W    = 24,
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0
) (
    input logic clk,
    input logic rst,
    pingpong_frame_buffer_if.slave bus
);
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW      = $clog2(DEPTH);
    localparam int LVL_W   = AW + 1;
    localparam int FRAME_W = NUM_CH * DATA_W;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
    localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [AW-1:0]    LAST_FRAME = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        READ
    } rd_state_t;

    rd_state_t state;

    logic [FRAME_W-1:0] mem [2][DEPTH];

    logic             wr_bank;
    logic [LVL_W-1:0] wr_level;
    logic             buffer_ready;
    logic             overflow;

    logic [AW-1:0]     rd_frame;
    logic [CH_W-1:0]   rd_chan;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [CH_W-1:0]   rd_ch;
    logic              rd_last;

    logic               full;
    logic               swap;
    logic               wr_en;
    logic               wr_sel_bank;
    logic [AW-1:0]      wr_addr;
    logic               overflow_event;
    logic [FRAME_W-1:0] rd_frame_word;
    logic [DATA_W-1:0]  rd_word;

    // A frame that coincides with a swap lands at index 0 of the bank that is
    // about to become the write bank.
    always_comb begin
        full           = (wr_level == FULL_LEVEL);
        swap           = full && (state == IDLE);
        wr_en          = 1'b0;
        wr_sel_bank    = wr_bank;
        wr_addr        = wr_level[AW-1:0];
        overflow_event = 1'b0;
        if (bus.frame_valid_i) begin
            if (swap) begin
                wr_en       = 1'b1;
                wr_sel_bank = ~wr_bank;
                wr_addr     = '0;
            end else if (!full) begin
                wr_en = 1'b1;
            end else begin
                overflow_event = 1'b1;
                if (OVERWRITE != 0) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel_bank][wr_addr] <= bus.frame_i;
        end
    end

    always_comb begin
        rd_frame_word = mem[~wr_bank][rd_frame];
        rd_word       = rd_frame_word[int'(rd_chan)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank      <= 1'b0;
            wr_level     <= '0;
            buffer_ready <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            buffer_ready <= swap;
            if (swap) begin
                wr_bank  <= ~wr_bank;
                wr_level <= {{(LVL_W-1){1'b0}}, bus.frame_valid_i};
            end else if (wr_en) begin
                wr_level <= full ? LVL_W'(1) : wr_level + 1'b1;
            end
            if (overflow_event) begin
                overflow <= 1'b1;
            end else if (bus.clear_i) begin
                overflow <= 1'b0;
            end
        end
    end

    // The output register reloads whenever it is empty or being consumed; the
    // handshake on the last word returns the FSM to IDLE instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_frame <= '0;
            rd_chan  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_ch    <= '0;
            rd_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (swap) begin
                        state    <= READ;
                        rd_frame <= '0;
                        rd_chan  <= '0;
                    end
                end
                READ: begin
                    if (!rd_valid || bus.rd_ready_i) begin
                        if (rd_valid && rd_last) begin
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_data  <= rd_word;
                            rd_ch    <= rd_chan;
                            rd_last  <= (rd_frame == LAST_FRAME) && (rd_chan == LAST_CH);
                            if (rd_chan == LAST_CH) begin
                                rd_chan  <= '0;
                                rd_frame <= rd_frame + 1'b1;
                            end else begin
                                rd_chan <= rd_chan + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_valid_o     = rd_valid;
    assign bus.rd_data_o      = rd_data;
    assign bus.rd_ch_o        = rd_ch;
    assign bus.rd_last_o      = rd_last;
    assign bus.buffer_ready_o = buffer_ready;
    assign bus.overflow_o     = overflow;
    assign bus.wr_level_o     = wr_level;
endmodule
